// File: rtl/knn_sched_if.sv
// Control and dataset-stream signals between the KNN register file, dataset RAM and knn_sched.
// The slave modport is the scheduler's view; the master modport is the surrounding peripheral's view.
interface knn_sched_if #(
    parameter int IDX_W     = 8,
    parameter int NT_POINTS = 4
);
    logic                 soft_rst;
    logic                 start;
    logic [IDX_W:0]       n_points;
    logic [NT_POINTS-1:0] core_ready;
    logic                 mem_ren;
    logic [IDX_W-1:0]     mem_addr;
    logic                 core_load;
    logic                 core_clear;
    logic                 busy;
    logic                 done;
    logic [IDX_W:0]       point_cnt;

    modport master (
        output soft_rst, start, n_points, core_ready,
        input  mem_ren, mem_addr, core_load, core_clear, busy, done, point_cnt
    );

    modport slave (
        input  soft_rst, start, n_points, core_ready,
        output mem_ren, mem_addr, core_load, core_clear, busy, done, point_cnt
    );
endinterface

// File: rtl/knn_sched.sv
// Sequencer for the knn_core array: clears neighbour lists, streams the dataset to all cores
// in lockstep, waits out the core pipeline and raises a sticky done.
//
// state   | meaning
// S_IDLE  | out of reset, waiting for start
// S_CLEAR | one-cycle clear of all neighbour lists
// S_FETCH | reading dataset points, stalls while any core is not ready
// S_DRAIN | waiting out the core pipeline after the last read
// S_DONE  | run complete, done held until the next accepted start
module knn_sched #(
    parameter int IDX_W     = 8,
    parameter int NT_POINTS = 4,
    parameter int DRAIN     = 4
) (
    input logic        clk,
    input logic        rst,
    knn_sched_if.slave bus
);
    localparam int              CW         = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [CW-1:0]   DRAIN_INIT = CW'(DRAIN - 1);
    localparam logic [IDX_W:0]  CNT_ONE    = (IDX_W + 1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   n_lat;
    logic [IDX_W:0]   point_cnt;
    logic [CW-1:0]    drain_cnt;
    logic             core_load;
    logic             core_clear;
    logic             busy;
    logic             done;
    logic             all_ready;
    logic             issue;
    logic             last_issue;

    // Readiness gates the read in the same cycle, so a core dropping ready never gets an extra point.
    assign all_ready  = &bus.core_ready;
    assign issue      = (state == S_FETCH) && all_ready;
    assign last_issue = ({1'b0, idx} == (n_lat - CNT_ONE));

    assign bus.mem_ren    = issue;
    assign bus.mem_addr   = idx;
    assign bus.core_load  = core_load;
    assign bus.core_clear = core_clear;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.point_cnt  = point_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            n_lat      <= '0;
            point_cnt  <= '0;
            drain_cnt  <= '0;
            core_load  <= 1'b0;
            core_clear <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (bus.soft_rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            n_lat      <= '0;
            point_cnt  <= '0;
            drain_cnt  <= '0;
            core_load  <= 1'b0;
            core_clear <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            core_load  <= issue;
            core_clear <= 1'b0;
            if (core_load) begin
                point_cnt <= point_cnt + CNT_ONE;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        if (bus.n_points != '0) begin
                            n_lat      <= bus.n_points;
                            state      <= S_CLEAR;
                            core_clear <= 1'b1;
                            busy       <= 1'b1;
                            done       <= 1'b0;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    idx       <= '0;
                    point_cnt <= '0;
                    state     <= S_FETCH;
                end
                S_FETCH: begin
                    if (issue) begin
                        idx <= idx + 1'b1;
                        if (last_issue) begin
                            state     <= S_DRAIN;
                            drain_cnt <= DRAIN_INIT;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == '0) begin
                        if (all_ready) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_knn_sched.sv
// Bench for knn_sched: each run is predicted cycle by cycle from the scheduling rules
// (issue on all-ready, load one cycle later, drain then done) and compared against the DUT.
module tb_knn_sched;
    localparam int IDX_W = 8;
    localparam int NT    = 4;
    localparam int DRN   = 4;
    localparam int MAXC  = 700;

    logic clk = 1'b0;
    logic rst = 1'b0;

    knn_sched_if #(.IDX_W(IDX_W), .NT_POINTS(NT)) bus ();

    knn_sched #(.IDX_W(IDX_W), .NT_POINTS(NT), .DRAIN(DRN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int prev_cnt = 0;

    logic [NT-1:0] rdy [MAXC];
    int e_ren [MAXC], e_addr [MAXC], e_load [MAXC], e_clr [MAXC];
    int e_busy [MAXC], e_done [MAXC], e_pc [MAXC];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    endtask

    task automatic check_zero(input string pfx);
        check_val({pfx, "_mem_ren"},    32'(bus.mem_ren),    0);
        check_val({pfx, "_mem_addr"},   32'(bus.mem_addr),   0);
        check_val({pfx, "_core_load"},  32'(bus.core_load),  0);
        check_val({pfx, "_core_clear"}, 32'(bus.core_clear), 0);
        check_val({pfx, "_busy"},       32'(bus.busy),       0);
        check_val({pfx, "_done"},       32'(bus.done),       0);
        check_val({pfx, "_point_cnt"},  32'(bus.point_cnt),  0);
    endtask

    // n: points; pct: random stall chance; st_lo..st_hi: cycles with core 2 forced not ready;
    // s2: cycle of an extra start pulse; sr: soft reset cycle; ar: cycle of async reset pulse (0 = none)
    task automatic run(input int n, input int pct, input int st_lo, input int st_hi,
                       input int s2, input int sr, input int ar);
        int c, issued, last_iss, d, cut, last;
        for (int i = 0; i < MAXC; i++) begin
            rdy[i] = '1;
            if (i < 600 && int'($urandom_range(99)) < pct) rdy[i][$urandom_range(NT - 1)] = 1'b0;
            if (i >= st_lo && i <= st_hi) rdy[i][2] = 1'b0;
            e_ren[i] = 0; e_addr[i] = 0; e_load[i] = 0; e_clr[i] = 0;
            e_busy[i] = 0; e_done[i] = 0; e_pc[i] = 0;
        end
        if (n == 0) begin
            last = 3;
            for (int k = 1; k <= last; k++) begin
                e_done[k] = 1;
                e_pc[k]   = prev_cnt;
            end
        end else begin
            e_clr[1] = 1;
            c = 2; issued = 0; last_iss = 2;
            while (issued < n) begin
                if (&rdy[c]) begin
                    e_ren[c] = 1; e_addr[c] = issued; issued++; last_iss = c;
                end
                c++;
            end
            d = last_iss + DRN;
            while (!(&rdy[d])) d++;
            last = d + 2;
            for (int k = 1; k <= last; k++) begin
                e_busy[k] = (k <= d) ? 1 : 0;
                e_done[k] = (k > d) ? 1 : 0;
                if (k >= 2) e_load[k] = e_ren[k-1];
                if (k == 1)      e_pc[k] = prev_cnt;
                else if (k == 2) e_pc[k] = 0;
                else             e_pc[k] = e_pc[k-1] + e_load[k-1];
            end
        end
        cut = (sr > 0) ? sr : ar;
        if (cut > 0) begin
            last = cut + 3;
            for (int k = cut + 1; k <= last; k++) begin
                e_ren[k] = 0; e_addr[k] = 0; e_load[k] = 0; e_clr[k] = 0;
                e_busy[k] = 0; e_done[k] = 0; e_pc[k] = 0;
            end
        end

        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.n_points   = (IDX_W + 1)'(n);
        bus.soft_rst   = 1'b0;
        bus.core_ready = rdy[0];
        for (int k = 1; k <= last; k++) begin
            @(posedge clk); #1;
            bus.start = (k == s2);
            if (k == s2) bus.n_points = (IDX_W + 1)'($urandom_range(1, 300));
            bus.soft_rst   = (k == sr);
            bus.core_ready = rdy[k];
            @(negedge clk);
            cyc = k;
            check_val("mem_ren",    32'(bus.mem_ren),    e_ren[k]);
            if (e_ren[k] == 1 || (cut > 0 && k > cut))
                check_val("mem_addr", 32'(bus.mem_addr), e_addr[k]);
            check_val("core_load",  32'(bus.core_load),  e_load[k]);
            check_val("core_clear", 32'(bus.core_clear), e_clr[k]);
            check_val("busy",       32'(bus.busy),       e_busy[k]);
            check_val("done",       32'(bus.done),       e_done[k]);
            check_val("point_cnt",  32'(bus.point_cnt),  e_pc[k]);
            if (k == ar) begin
                #1 rst = 1'b0;
                #1 check_zero("arst");
                #1 rst = 1'b1;
            end
        end
        if (cut > 0)     prev_cnt = 0;
        else if (n != 0) prev_cnt = n;
    endtask

    initial begin
        int n, sr, s2;
        bus.start = 1'b0; bus.soft_rst = 1'b0; bus.n_points = '0; bus.core_ready = '1;
        #3 check_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        cyc = 0;
        check_zero("post_reset");

        run(0,   0, -1, -1, 0, 0, 0);   // zero length from idle
        run(5,   0, -1, -1, 0, 0, 0);   // basic
        run(3,   0,  3,  5, 0, 0, 0);   // backpressure on core 2
        run(10,  0, -1, -1, 5, 0, 0);   // start ignored mid-fetch
        run(2,   0, -1, -1, 0, 0, 0);   // restart from done
        run(0,   0, -1, -1, 0, 0, 0);   // zero length from done
        run(5,   0, -1, -1, 0, 4, 0);   // soft reset during fetch
        run(5,   0, -1, -1, 0, 0, 8);   // async reset during drain
        run(256, 0, -1, -1, 0, 0, 0);   // full dataset range

        for (int r = 0; r < 14; r++) begin
            n  = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(1, 40));
            s2 = (n >= 3 && $urandom_range(1) == 1) ? int'($urandom_range(3, n + 1)) : 0;
            sr = (n >= 1 && $urandom_range(3) == 0) ? int'($urandom_range(1, n + 1)) : 0;
            run(n, int'($urandom_range(30)), -1, -1, s2, sr, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
